// File: rtl/axil_pkg.sv
// Shared AXI-lite response codes and read-side state type, also used by the
// write bridge and the arbiter that merges the two channels.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        FLUSH
    } rd_state_t;

endpackage

// File: rtl/axil_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding {data, resp} read beats.
// pop_data is valid whenever empty is low; reset empties the FIFO.
module axil_rsp_fifo #(
    parameter int WIDTH   = 34,
    parameter int LGDEPTH = 3
) (
    input  logic               i_clk,
    input  logic               w_reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic               empty,
    output logic               full,
    output logic [LGDEPTH:0]   fill
);

    logic [WIDTH-1:0]   mem [0:(1<<LGDEPTH)-1];
    logic [LGDEPTH-1:0] wr_ptr;
    logic [LGDEPTH-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty    = (fill == '0);
    // fill never exceeds the depth, so its MSB alone marks full
    assign full     = fill[LGDEPTH];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + LGDEPTH'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + LGDEPTH'(1);
            case ({do_push, do_pop})
                2'b10:   fill <= fill + (LGDEPTH+1)'(1);
                2'b01:   fill <= fill - (LGDEPTH+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axilrd2wb_bridge.sv
// AXI-lite read channel to pipelined Wishbone master, with an in-order response
// FIFO so that R-channel backpressure never stalls the bus.
//
//   state | meaning
//   IDLE  | no bus cycle open
//   BUS   | reads strobed or awaiting ack
//   FLUSH | bus error seen; emitting one SLVERR beat per abandoned read
module axilrd2wb_bridge
    import axil_pkg::*;
#(
    parameter int  C_AXI_DATA_WIDTH = 32,
    parameter int  C_AXI_ADDR_WIDTH = 28,
    parameter int  LGFIFO           = 3,
    localparam int DW               = C_AXI_DATA_WIDTH,
    localparam int AW               = C_AXI_ADDR_WIDTH - $clog2(C_AXI_DATA_WIDTH/8)
) (
    input  logic            i_clk,
    input  logic            w_reset,
    input  logic            i_axi_arvalid,
    output logic            o_axi_arready,
    input  logic [AW-1:0]   i_axi_araddr,
    input  logic [2:0]      i_axi_arprot,
    output logic            o_axi_rvalid,
    input  logic            i_axi_rready,
    output logic [DW-1:0]   o_axi_rdata,
    output logic [1:0]      o_axi_rresp,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_ack,
    input  logic            i_wb_stall,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    localparam logic [LGFIFO:0] DEPTH = {1'b1, {LGFIFO{1'b0}}};
    localparam logic [LGFIFO:0] ONE   = {{LGFIFO{1'b0}}, 1'b1};

    rd_state_t       state;
    logic [LGFIFO:0] credits;
    logic [LGFIFO:0] credits_nxt;
    logic [LGFIFO:0] wb_out;
    logic [LGFIFO:0] wb_out_nxt;
    logic [LGFIFO:0] flush_n;
    logic            stb_nxt;
    logic            accept;
    logic            r_hs;
    logic            issue;
    logic            ack_v;
    logic            err_v;
    logic            fifo_push;
    logic [DW+1:0]   fifo_wdata;
    logic [DW+1:0]   fifo_rdata;
    logic            fifo_empty;
    logic            fifo_full;
    logic [LGFIFO:0] fifo_fill;
    logic            unused_ok;

    assign o_axi_arready = !w_reset && (state != FLUSH) && (credits < DEPTH)
                           && (!o_wb_stb || !i_wb_stall);
    assign accept   = i_axi_arvalid && o_axi_arready;
    assign r_hs     = o_axi_rvalid && i_axi_rready;
    assign issue    = o_wb_stb && !i_wb_stall;
    assign o_wb_cyc = o_wb_stb || (wb_out != '0);
    assign ack_v    = i_wb_ack && o_wb_cyc;
    assign err_v    = i_wb_err && o_wb_cyc;
    assign o_wb_sel = '1;

    assign o_axi_rvalid = !fifo_empty;
    assign o_axi_rdata  = fifo_rdata[DW+1:2];
    assign o_axi_rresp  = fifo_empty ? RESP_OKAY : fifo_rdata[1:0];

    assign unused_ok = &{1'b0, i_axi_arprot, fifo_full, fifo_fill};

    always_comb begin
        credits_nxt = credits;
        case ({accept, r_hs})
            2'b10:   credits_nxt = credits + ONE;
            2'b01:   credits_nxt = credits - ONE;
            default: credits_nxt = credits;
        endcase
        wb_out_nxt = wb_out;
        case ({issue, ack_v})
            2'b10:   wb_out_nxt = wb_out + ONE;
            2'b01:   wb_out_nxt = wb_out - ONE;
            default: wb_out_nxt = wb_out;
        endcase
        stb_nxt = accept || (o_wb_stb && i_wb_stall);
    end

    always_comb begin
        fifo_push  = 1'b0;
        fifo_wdata = {i_wb_data, RESP_OKAY};
        if (state == FLUSH) begin
            fifo_push  = (flush_n != '0);
            fifo_wdata = {{DW{1'b0}}, RESP_SLVERR};
        end else if (ack_v && !err_v) begin
            fifo_push  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            state    <= IDLE;
            o_wb_stb <= 1'b0;
            credits  <= '0;
            wb_out   <= '0;
            flush_n  <= '0;
        end else begin
            credits <= credits_nxt;
            case (state)
                FLUSH: begin
                    if (flush_n <= ONE)
                        state <= IDLE;
                    if (flush_n != '0)
                        flush_n <= flush_n - ONE;
                end
                default: begin
                    if (err_v) begin
                        // an AR taken in the error cycle is never strobed,
                        // so it is answered with SLVERR along with the rest
                        o_wb_stb <= 1'b0;
                        wb_out   <= '0;
                        flush_n  <= wb_out + {{LGFIFO{1'b0}}, o_wb_stb}
                                           + {{LGFIFO{1'b0}}, accept};
                        state    <= FLUSH;
                    end else begin
                        o_wb_stb <= stb_nxt;
                        wb_out   <= wb_out_nxt;
                        state    <= (stb_nxt || (wb_out_nxt != '0)) ? BUS : IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept)
            o_wb_addr <= i_axi_araddr;
    end

    axil_rsp_fifo #(
        .WIDTH   (DW + 2),
        .LGDEPTH (LGFIFO)
    ) u_rsp_fifo (
        .i_clk     (i_clk),
        .w_reset   (w_reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (r_hs),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .fill      (fifo_fill)
    );

endmodule

// File: tb/tb_axilrd2wb_bridge.sv
// Directed bench for axilrd2wb_bridge: a transaction-level model (queues of
// expected addresses and R beats) is compared against the DUT every cycle.
module tb_axilrd2wb_bridge;
    import axil_pkg::*;

    logic        i_clk;
    logic        w_reset;
    logic        i_axi_arvalid;
    logic        o_axi_arready;
    logic [25:0] i_axi_araddr;
    logic [2:0]  i_axi_arprot;
    logic        o_axi_rvalid;
    logic        i_axi_rready;
    logic [31:0] o_axi_rdata;
    logic [1:0]  o_axi_rresp;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [25:0] o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic        i_wb_err;
    logic [31:0] i_wb_data;

    axilrd2wb_bridge dut (
        .i_clk         (i_clk),
        .w_reset       (w_reset),
        .i_axi_arvalid (i_axi_arvalid),
        .o_axi_arready (o_axi_arready),
        .i_axi_araddr  (i_axi_araddr),
        .i_axi_arprot  (i_axi_arprot),
        .o_axi_rvalid  (o_axi_rvalid),
        .i_axi_rready  (i_axi_rready),
        .o_axi_rdata   (o_axi_rdata),
        .o_axi_rresp   (o_axi_rresp),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_addr     (o_wb_addr),
        .o_wb_sel      (o_wb_sel),
        .i_wb_ack      (i_wb_ack),
        .i_wb_stall    (i_wb_stall),
        .i_wb_err      (i_wb_err),
        .i_wb_data     (i_wb_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        int          vis;
    } beat_t;

    beat_t       exp_q[$];
    logic [25:0] addr_q[$];
    int          ar_cnt, rhs_cnt, beat_cnt, bus_pend, flush_rem, cyc_i;
    int          r_total, slv_total;

    initial begin
        logic exp_stb, exp_cyc, exp_rv, exp_ar, acc, iss, ack, err;
        int   n;
        cyc_i = 0; ar_cnt = 0; rhs_cnt = 0; beat_cnt = 0; bus_pend = 0; flush_rem = 0;
        r_total = 0; slv_total = 0;
        forever begin
            @(negedge i_clk);
            cyc_i++;
            if (w_reset) begin
                chk("arready_in_reset", o_axi_arready, 0);
                exp_q.delete(); addr_q.delete();
                ar_cnt = 0; rhs_cnt = 0; beat_cnt = 0; bus_pend = 0; flush_rem = 0;
            end else begin
                exp_stb = (addr_q.size() > 0);
                exp_cyc = exp_stb || (bus_pend > 0);
                exp_rv  = (exp_q.size() > 0) && (exp_q[0].vis <= cyc_i);
                exp_ar  = (flush_rem == 0) && ((ar_cnt - rhs_cnt) < 8) && (!exp_stb || !i_wb_stall);
                chk("stb", o_wb_stb, exp_stb);
                chk("cyc", o_wb_cyc, exp_cyc);
                chk("rvalid", o_axi_rvalid, exp_rv);
                chk("arready", o_axi_arready, exp_ar);
                if (exp_stb) begin
                    chk("wb_addr", o_wb_addr, addr_q[0]);
                    chk("wb_sel", o_wb_sel, 4'hF);
                end
                if (exp_rv) begin
                    chk("rdata", o_axi_rdata, exp_q[0].d);
                    chk("rresp", o_axi_rresp, exp_q[0].r);
                end
                if (o_axi_rvalid && i_axi_rready) begin
                    r_total++;
                    if (o_axi_rresp == RESP_SLVERR) slv_total++;
                end
                // events taking effect at the coming edge
                if (flush_rem > 0) flush_rem--;
                acc = i_axi_arvalid && exp_ar;
                iss = exp_stb && !i_wb_stall;
                err = i_wb_err && exp_cyc;
                ack = i_wb_ack && exp_cyc && !err;
                if (iss) begin
                    void'(addr_q.pop_front());
                    bus_pend++;
                end
                if (ack) begin
                    exp_q.push_back('{i_wb_data, RESP_OKAY, cyc_i + 1});
                    bus_pend--;
                    beat_cnt++;
                end
                if (acc) begin
                    addr_q.push_back(i_axi_araddr);
                    ar_cnt++;
                end
                if (err) begin
                    n = ar_cnt - beat_cnt;
                    for (int k = 1; k <= n; k++)
                        exp_q.push_back('{32'h0, RESP_SLVERR, cyc_i + 1 + k});
                    beat_cnt  = ar_cnt;
                    addr_q.delete();
                    bus_pend  = 0;
                    flush_rem = n;
                end
                if (exp_rv && i_axi_rready) begin
                    void'(exp_q.pop_front());
                    rhs_cnt++;
                end
            end
        end
    end

    // ---------------- Wishbone responder ----------------
    logic        auto_ack;
    int          err_req, err_done, late_req, late_done;
    logic [25:0] rsp_q[$];

    function automatic logic [31:0] data_of(input logic [25:0] a);
        if (a == 26'h123) return 32'hDEADBEEF;
        return {6'h0, a} ^ 32'hC0DE_0000;
    endfunction

    initial begin
        i_wb_ack = 0; i_wb_err = 0; i_wb_data = 0;
        err_done = 0; late_done = 0;
        forever begin
            @(negedge i_clk);
            if (w_reset) rsp_q.delete();
            else if (o_wb_stb && !i_wb_stall) rsp_q.push_back(o_wb_addr);
            @(posedge i_clk); #1;
            i_wb_ack = 0;
            i_wb_err = 0;
            if (err_req != err_done) begin
                i_wb_err = 1;
                err_done = err_req;
                rsp_q.delete();
            end else if (late_req != late_done) begin
                i_wb_ack  = 1;
                i_wb_data = 32'h1111_1111;
                late_done = late_req;
            end else if (auto_ack && rsp_q.size() > 0) begin
                i_wb_ack  = 1;
                i_wb_data = data_of(rsp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic ar_send(input logic [25:0] a);
        logic acc = 0;
        i_axi_araddr  = a;
        i_axi_arvalid = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge i_clk);
            acc = o_axi_arready;
            @(posedge i_clk); #1;
            if (acc) break;
        end
        i_axi_arvalid = 0;
        chk("ar_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        logic done = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge i_clk);
            if (!o_wb_cyc && !o_axi_rvalid && exp_q.size() == 0 && addr_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        chk("idle_reached", done, 1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int   r0, s0;
        logic seen;
        w_reset = 1; i_axi_arvalid = 0; i_axi_araddr = 0; i_axi_arprot = 0;
        i_axi_rready = 0; i_wb_stall = 0; auto_ack = 0; err_req = 0; late_req = 0;
        repeat (3) step();
        w_reset = 0;
        @(negedge i_clk);
        chk("post_reset_cyc", o_wb_cyc, 0);
        chk("post_reset_rvalid", o_axi_rvalid, 0);
        chk("post_reset_arready", o_axi_arready, 1);
        @(posedge i_clk); #1;

        // single read
        auto_ack = 1; i_axi_rready = 1;
        ar_send(26'h0000123);
        @(negedge i_clk);
        chk("single_stb", o_wb_stb, 1);
        chk("single_addr", o_wb_addr, 26'h123);
        chk("single_sel", o_wb_sel, 4'hF);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            if (o_axi_rvalid) begin seen = 1; break; end
            @(negedge i_clk);
        end
        chk("single_rvalid_seen", seen, 1);
        chk("single_rdata", o_axi_rdata, 32'hDEADBEEF);
        chk("single_rresp", o_axi_rresp, 2'b00);
        @(posedge i_clk); #1;
        wait_idle();

        // eight back-to-back, stall on the second strobe
        fork
            begin
                for (int i = 0; i < 8; i++) ar_send(26'h200 + 26'(i));
            end
            begin
                step(); step();
                i_wb_stall = 1;
                repeat (3) step();
                i_wb_stall = 0;
            end
        join
        wait_idle();

        // credit limit with rready held low
        i_axi_rready = 0;
        for (int i = 0; i < 8; i++) ar_send(26'h300 + 26'(i));
        i_axi_araddr = 26'h308; i_axi_arvalid = 1;
        repeat (4) step();
        @(negedge i_clk);
        chk("credit_block", o_axi_arready, 0);
        @(posedge i_clk); #1;
        i_axi_rready = 1;
        step();
        i_axi_rready = 0;
        @(negedge i_clk);
        chk("credit_release", o_axi_arready, 1);
        @(posedge i_clk); #1;
        i_axi_arvalid = 0;
        i_axi_rready  = 1;
        wait_idle();

        // bus error with three reads outstanding
        auto_ack = 0;
        s0 = slv_total;
        for (int i = 0; i < 3; i++) ar_send(26'h400 + 26'(i));
        repeat (3) step();
        err_req++;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge i_clk);
            if (i_wb_err) begin seen = 1; break; end
        end
        chk("err_driven", seen, 1);
        @(negedge i_clk);
        chk("err_cyc_drop", o_wb_cyc, 0);
        @(posedge i_clk); #1;
        late_req++;
        wait_idle();
        chk("slverr_beats", slv_total - s0, 3);
        auto_ack = 1;
        ar_send(26'h55);
        wait_idle();

        // reset with two outstanding and one queued
        i_axi_rready = 0;
        ar_send(26'h500);
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge i_clk);
            if (o_axi_rvalid) begin seen = 1; break; end
        end
        chk("queued_before_reset", seen, 1);
        @(posedge i_clk); #1;
        auto_ack = 0;
        ar_send(26'h501);
        ar_send(26'h502);
        repeat (2) step();
        w_reset = 1;
        step();
        w_reset = 0;
        @(negedge i_clk);
        chk("midreset_cyc", o_wb_cyc, 0);
        chk("midreset_rvalid", o_axi_rvalid, 0);
        chk("midreset_arready", o_axi_arready, 1);
        @(posedge i_clk); #1;
        i_axi_rready = 1; auto_ack = 1;
        ar_send(26'h503);
        wait_idle();

        // R backpressure toggling
        i_axi_rready = 0;
        r0 = r_total;
        for (int i = 0; i < 4; i++) ar_send(26'h600 + 26'(i));
        repeat (6) step();
        for (int i = 0; i < 16; i++) begin
            i_axi_rready = (i % 2 == 0);
            step();
        end
        i_axi_rready = 1;
        wait_idle();
        chk("bp_beats", r_total - r0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
